// File: rtl/fmul_norm_round.sv
// fmul_norm_round: two-stage normalize / round / pack back end of a binary16
// multiplier, with valid/ready handshakes on both sides.
module fmul_norm_round #(
    parameter int MW = 11
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*MW-1:0] in_prod,
    input  logic [7:0]      in_exp,
    input  logic            in_sign,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_result,
    output logic            out_ovf,
    output logic            out_unf,
    output logic            out_inexact
);

    localparam int PW = 2 * MW;

    logic                s1_valid_q, s1_valid_d;
    logic                s1_sign_q, s1_sign_d;
    logic                s1_zero_q, s1_zero_d;
    logic                s1_nz_q, s1_nz_d;
    logic [MW-1:0]       s1_mant_q, s1_mant_d;
    logic                s1_guard_q, s1_guard_d;
    logic                s1_sticky_q, s1_sticky_d;
    logic signed [8:0]   s1_exp_q, s1_exp_d;

    logic                out_valid_q, out_valid_d;
    logic [15:0]         out_result_q, out_result_d;
    logic                out_ovf_q, out_ovf_d;
    logic                out_unf_q, out_unf_d;
    logic                out_inexact_q, out_inexact_d;

    logic                s1_adv;
    logic                in_fire;
    logic                top;
    logic [MW-1:0]       mant_n;
    logic                guard_n;
    logic                sticky_n;
    logic signed [8:0]   exp_n;

    logic                inc;
    logic [MW:0]         mant_r;
    logic signed [8:0]   exp_r;
    logic [9:0]          frac_r;

    assign s1_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;

    // Product is in [1,4): leading one sits in one of the top two bits.
    assign top      = in_prod[PW-1];
    assign mant_n   = top ? in_prod[PW-1 -: MW] : in_prod[PW-2 -: MW];
    assign guard_n  = top ? in_prod[PW-1-MW] : in_prod[PW-2-MW];
    assign sticky_n = top ? |in_prod[PW-2-MW:0] : |in_prod[PW-3-MW:0];
    assign exp_n    = $signed({in_exp[7], in_exp}) + (top ? 9'sd1 : 9'sd0);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_zero_d   = s1_zero_q;
        s1_nz_d     = s1_nz_q;
        s1_mant_d   = s1_mant_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_exp_d    = s1_exp_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_sign_d   = in_sign;
            s1_zero_d   = ~|in_prod[PW-1:PW-2];
            s1_nz_d     = |in_prod;
            s1_mant_d   = mant_n;
            s1_guard_d  = guard_n;
            s1_sticky_d = sticky_n;
            s1_exp_d    = exp_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_nz_q     <= 1'b0;
            s1_mant_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_exp_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_nz_q     <= s1_nz_d;
            s1_mant_q   <= s1_mant_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_exp_q    <= s1_exp_d;
        end
    end

    // Round to nearest even; a carry out renormalizes to 1.0 * 2^(e+1).
    assign inc    = s1_guard_q && (s1_sticky_q || s1_mant_q[0]);
    assign mant_r = {1'b0, s1_mant_q} + {{MW{1'b0}}, inc};
    assign exp_r  = mant_r[MW] ? (s1_exp_q + 9'sd1) : s1_exp_q;
    assign frac_r = mant_r[MW] ? 10'h000 : mant_r[MW-2 -: 10];

    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_ovf_d     = out_ovf_q;
        out_unf_d     = out_unf_q;
        out_inexact_d = out_inexact_q;
        if (s1_adv) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_adv && s1_valid_q) begin
            unique case (1'b1)
                s1_zero_q: begin
                    out_result_d  = {s1_sign_q, 15'h0000};
                    out_ovf_d     = 1'b0;
                    out_unf_d     = s1_nz_q;
                    out_inexact_d = s1_nz_q;
                end
                (exp_r >= 9'sd31): begin
                    out_result_d  = {s1_sign_q, 5'h1F, 10'h000};
                    out_ovf_d     = 1'b1;
                    out_unf_d     = 1'b0;
                    out_inexact_d = 1'b1;
                end
                (exp_r <= 9'sd0): begin
                    out_result_d  = {s1_sign_q, 15'h0000};
                    out_ovf_d     = 1'b0;
                    out_unf_d     = 1'b1;
                    out_inexact_d = 1'b1;
                end
                default: begin
                    out_result_d  = {s1_sign_q, exp_r[4:0], frac_r};
                    out_ovf_d     = 1'b0;
                    out_unf_d     = 1'b0;
                    out_inexact_d = s1_guard_q | s1_sticky_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_ovf_q     <= 1'b0;
            out_unf_q     <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_ovf_q     <= out_ovf_d;
            out_unf_q     <= out_unf_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_ovf     = out_ovf_q;
    assign out_unf     = out_unf_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fmul_norm_round.sv
// tb_fmul_norm_round: directed vectors with hand-computed binary16 results,
// plus latency, streaming, backpressure and mid-flight reset scenarios.
module tb_fmul_norm_round;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [21:0] in_prod = '0;
    logic [7:0]  in_exp = '0;
    logic        in_sign = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    int checks = 0;
    int failures = 0;

    localparam int NV = 16;

    // flags are {ovf, unf, inexact}
    logic [21:0] v_prod [NV] = '{
        22'h100000, 22'h3FF001, 22'h1FFE00, 22'h100000,
        22'h100000, 22'h000000, 22'h0FFFFF, 22'h3FF001,
        22'h1FFE00, 22'h100000, 22'h100000, 22'h100200,
        22'h100600, 22'h200000, 22'h3FFFFF, 22'h3FFFFF};
    logic [7:0]  v_exp  [NV] = '{
        8'd15, 8'd15, 8'd15, 8'd31,
        8'd0,  8'd7,  8'd15, 8'd29,
        8'd30, 8'd1,  8'hC0, 8'd15,
        8'd15, 8'd63, 8'd14, 8'hFF};
    logic        v_sign [NV] = '{
        1'b0, 1'b0, 1'b0, 1'b1,
        1'b0, 1'b1, 1'b0, 1'b0,
        1'b1, 1'b0, 1'b0, 1'b0,
        1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] v_res  [NV] = '{
        16'h3C00, 16'h43FE, 16'h4000, 16'hFC00,
        16'h0000, 16'h8000, 16'h0000, 16'h7BFE,
        16'hFC00, 16'h0400, 16'h0000, 16'h3C00,
        16'hBC02, 16'h7C00, 16'h4000, 16'h0400};
    logic [2:0]  v_flg  [NV] = '{
        3'b000, 3'b001, 3'b001, 3'b101,
        3'b011, 3'b000, 3'b011, 3'b001,
        3'b101, 3'b000, 3'b011, 3'b001,
        3'b001, 3'b101, 3'b001, 3'b001};

    fmul_norm_round #(.MW(11)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_prod     (in_prod),
        .in_exp      (in_exp),
        .in_sign     (in_sign),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_unf     (out_unf),
        .out_inexact (out_inexact)
    );

    always #5 clock = ~clock;

    task automatic drive(input int k);
        in_valid = 1'b1;
        in_prod  = v_prod[k];
        in_exp   = v_exp[k];
        in_sign  = v_sign[k];
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000) begin
            failures++;
            $display("FAIL reset_out: valid=%b result=%h required valid=0 result=0000",
                     out_valid, out_result);
        end
        checks++;
        if ({out_ovf, out_unf, out_inexact} !== 3'b000 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags: flags=%b in_ready=%b required flags=000 in_ready=1",
                     {out_ovf, out_unf, out_inexact}, in_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_vectors;
        for (int k = 0; k < NV; k++) begin
            drive(k);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_in_ready: got %b required 1", k, in_ready);
            end
            @(negedge clock);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL vec%0d_early_valid: got %b required 0", k, out_valid);
            end
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_result !== v_res[k]) begin
                failures++;
                $display("FAIL vec%0d_result: valid=%b result=%h required valid=1 result=%h",
                         k, out_valid, out_result, v_res[k]);
            end
            checks++;
            if ({out_ovf, out_unf, out_inexact} !== v_flg[k]) begin
                failures++;
                $display("FAIL vec%0d_flags: got %b required %b",
                         k, {out_ovf, out_unf, out_inexact}, v_flg[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int seq [4] = '{1, 2, 12, 14};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== v_res[seq[i-2]]) begin
                    failures++;
                    $display("FAIL b2b_%0d: valid=%b result=%h required valid=1 result=%h",
                             i - 2, out_valid, out_result, v_res[seq[i-2]]);
                end
            end
            if (i < 4) drive(seq[i]);
            else in_valid = 1'b0;
            @(negedge clock);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(0);
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second_accept: in_ready=%b required 1", in_ready);
        end
        drive(1);
        @(negedge clock);
        drive(2);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: in_ready=%b required 0", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== v_res[0] ||
                {out_ovf, out_unf, out_inexact} !== v_flg[0]) begin
                failures++;
                $display("FAIL bp_hold%0d: valid=%b result=%h required valid=1 result=%h",
                         c, out_valid, out_result, v_res[0]);
            end
            @(negedge clock);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_still_full: in_ready=%b required 0", in_ready);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b required 1", in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== v_res[c] ||
                {out_ovf, out_unf, out_inexact} !== v_flg[c]) begin
                failures++;
                $display("FAIL bp_order%0d: valid=%b result=%h required valid=1 result=%h",
                         c, out_valid, out_result, v_res[c]);
            end
            @(negedge clock);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_midreset;
        out_ready = 1'b0;
        drive(1);
        @(negedge clock);
        drive(3);
        @(negedge clock);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mr_full: valid=%b in_ready=%b required valid=1 in_ready=0",
                     out_valid, in_ready);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000 ||
            {out_ovf, out_unf, out_inexact} !== 3'b000 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mr_clear: valid=%b result=%h flags=%b in_ready=%b required 0 0000 000 1",
                     out_valid, out_result, {out_ovf, out_unf, out_inexact}, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mr_ghost%0d: valid=%b result=%h required valid=0",
                         c, out_valid, out_result);
            end
        end
        drive(13);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_result !== v_res[13]) begin
            failures++;
            $display("FAIL mr_recover: valid=%b result=%h required valid=1 result=%h",
                     out_valid, out_result, v_res[13]);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmul_norm_round.md
FMUL_NORM_ROUND -- requirements
Module: fmul_norm_round

Interface
REQ-001 SHALL have parameter MW, default 11, meaning significand width including hidden bit; the product input is 2*MW bits wide; all values below are for MW=11.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream product and exponent valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_prod  input  22  unsigned significand product from the mantissa multiplier.
REQ-007 SHALL have port in_exp  input  8  two's-complement biased exponent sum ea+eb-15; valid range -64..63.
REQ-008 SHALL have port in_sign  input  1  result sign (sa XOR sb).
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-011 SHALL have port out_result  output  16  IEEE binary16 result.
REQ-012 SHALL have ports out_ovf, out_unf, out_inexact  output  1 each  overflow, underflow/flush, and inexact flags, valid with out_valid.

Function
REQ-013 SHALL be a two-stage valid/ready pipeline. S1 performs normalize and extracts guard/sticky. S2 performs round, the exponent range check, and packing. Both stages are registered.
REQ-014 SHALL transfer on the input side when in_valid&&in_ready, and on the output side when out_valid&&out_ready.
REQ-015 SHALL set in_ready = !s1_valid || (s1 advances this cycle). S1 advances when !s2_valid || out_ready. This gives a throughput of 1 result per cycle with no bubbles.
REQ-016 SHALL produce out_valid exactly 2 cycles after the accepting edge while out_ready is held high.
REQ-017 SHALL hold out_result and all flags stable while out_valid && !out_ready. SHALL never drop, duplicate or reorder a transaction.
REQ-018 When in_prod[21]=1, SHALL use mant=in_prod[21:11], guard=in_prod[10], sticky=|in_prod[9:0], and e=in_exp+1.
REQ-019 When in_prod[21:20]=01, SHALL use mant=in_prod[20:10], guard=in_prod[9], sticky=|in_prod[8:0], and e=in_exp.
REQ-020 When in_prod[21:20]=00, SHALL output signed zero {in_sign,15'b0}. out_unf SHALL be 1 iff in_prod!=0; out_inexact SHALL equal out_unf.
REQ-021 SHALL round to nearest, ties to even: increment when guard && (sticky || mant[0]).
REQ-022 When the increment carries out (mant becomes 2^11), SHALL set the fraction to 0 and apply e=e+1.
REQ-023 SHALL perform all exponent arithmetic at 9-bit signed width, with no wrap.
REQ-024 If final e>=31: out_result={sign,5'h1F,10'h0}, out_ovf=1, out_inexact=1.
REQ-025 If final e<=0: out_result={sign,15'b0}, out_unf=1, out_inexact=1. No subnormals are produced.
REQ-026 Otherwise: out_result={sign,e[4:0],frac[9:0]}, out_ovf=out_unf=0, out_inexact=guard|sticky.

Reset
REQ-027 SHALL force s1_valid, s2_valid and out_valid to 0 while reset_n=0.
REQ-028 SHALL force out_result, out_ovf, out_unf and out_inexact to 0 while reset_n=0.
REQ-029 SHALL hold in_ready=1 while reset_n=0.
REQ-030 SHALL discard in-flight transactions on a reset asserted mid-operation. No result for them SHALL appear after release.
REQ-031 SHALL accept input on the first rising edge after reset_n deasserts.

Verification
REQ-032 Identity: prod=0x100000 (1024*1024), exp=15, sign=0, out_ready=1 -> 2 cycles later out_result=0x3C00, all flags 0.
REQ-033 Max product: prod=0x3FF001 (2047*2047), exp=15 -> out_result=0x43FE, out_inexact=1, ovf=unf=0.
REQ-034 Round carry: prod=0x1FFE00, exp=15 -> out_result=0x4000, out_inexact=1.
REQ-035 Range: prod=0x100000 with exp=31, sign=1 -> 0xFC00 with ovf=1. Same prod with exp=0, sign=0 -> 0x0000 with unf=1. prod=0, sign=1 -> 0x8000 with all flags 0.
REQ-036 Backpressure: out_ready=0, drive 3 back-to-back inputs -> in_ready falls after 2 accepts and out_result holds the first result. Then out_ready=1 -> 3 results emerge in order on consecutive cycles.
REQ-037 Reset: pulse reset_n low with both stages full -> out_valid=0 and out_result=0 immediately. Nothing is emitted after release until new input arrives.
